// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM state
// encoding and the default operand width.
package serial_addsub_pkg;

    localparam int SERIAL_ADDSUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder: the one arithmetic slice the serial unit reuses
// every clock.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial, LSB-first add/subtract unit built around one full_adder.
// One operand bit is consumed per clock; a result takes WIDTH clocks.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds the signed overflow
// output ovf (carry-in XOR carry-out of the MSB slice).
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] s_sr_q;
    logic [WIDTH-1:0] s_sr_d;
    logic             carry_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             sum_bit;
    logic             co_bit;
    logic             accept;
    logic             last_bit;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q;
`endif

    // The unit is busy only while bits are being shifted through the slice;
    // in DONE it can already take the next request.
    assign ready    = (state_q != RUN);
    assign done     = (state_q == DONE);
    assign accept   = start && ready;
    assign last_bit = (state_q == RUN) && (cnt_q == LAST_CNT);

    // The single arithmetic slice; carry_q closes the loop between bits.
    full_adder u_fa (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .ci_i (carry_q),
        .s_o  (sum_bit),
        .co_o (co_bit)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign s_sr_d = {sum_bit, s_sr_q[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DONE lasts one cycle unless a new request chains in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand/sum shift registers, bit counter and carry; results are
    // captured only on the edge that processes the final (MSB) bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
            a_sr_q  <= a;
            b_sr_q  <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sr_q  <= a_sr_q >> 1;
            b_sr_q  <= b_sr_q >> 1;
            s_sr_q  <= s_sr_d;
            carry_q <= co_bit;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                s_q    <= s_sr_d;
                cout_q <= co_bit;
`ifdef SERIAL_ADDSUB_OVF_EN
                // carry_q is the carry into the MSB slice on this edge.
                ovf_q  <= carry_q ^ co_bit;
`endif
            end
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
